irq_ctrl: RTL and testbench
===========================

# irq_ctrl

Interrupt request controller sitting directly upstream of the PC stage. Synchronises three raw interrupt sources (level 3 highest), detects rising edges, and latches them as pending. It presents at most one request at a time on the PC's `interrupt1..3` inputs, and holds it until the PC acknowledges it by raising the matching `interruptN_running`. It tracks the current service level and masking, and reports service statistics and protocol errors.

## Interface
- `SYNC_STAGES`, 2: flip-flops in each input synchroniser; minimum 2.
- `CNT_W`, 8: width of the serviced-interrupt counter.

- `clk`  in  1  system clock; all logic on rising edge.
- `clr_n`  in  1  reset, synchronous, active-low.
- `irq_raw`  in  3  asynchronous sources; bit i = level i+1.
- `irq_mask`  in  3  1 = level masked. Masked levels still latch pending but are never issued.
- `running`  in  3  from PC `interrupt1..3_running`.
- `done`  in  3  from decoder `interrupt1..3_done`; single-cycle pulses.
- `irq_out`  out  3  to PC `interrupt1..3`; one-hot or zero.
- `pending`  out  3  latched, not-yet-acknowledged requests.
- `cur_level`  out  2  highest running level; 0 = user code.
- `svc_cnt`  out  CNT_W  count of acknowledged interrupts, saturating.
- `lost`  out  1  sticky; an edge arrived while its level was already pending.
- `err_done`  out  1  sticky; `done[i]` seen while `running[i]` was 0.

## Operation
- **Reset** (`clr_n`=0 at an edge): synchronisers, edge registers, `pending`, `irq_out`, `svc_cnt`, `lost` and `err_done` all go to 0. A raw input already high at reset release produces exactly one request.
- **Edge detect:** `rise[i] = sync[i] & ~sync_d[i]`.
- **Pending set/clear:**
  - `pending[i]` is set on `rise[i]`.
  - It is cleared on the cycle the acknowledge is detected: `running[i]` rises, i.e. `running[i] & ~running_d[i]`.
  - If `rise[i]` and the acknowledge happen in the same cycle, `pending[i]` stays 1.
  - If `rise[i]` arrives while `pending[i]` is already 1 with no acknowledge, the edge is merged and `lost` is set.
- **Eligibility:** level L is eligible when all of the following hold:
  - `pending[L]` = 1;
  - `irq_mask[L]` = 0;
  - L > `cur_level`;
  - `running[L]` = 0.
- **Issue (registered):** `irq_out` is one-hot at the highest eligible level, otherwise 0.
  - Preemption before acknowledge: if a higher level becomes eligible while a lower one is on `irq_out`, `irq_out` switches to the higher level on the next edge.
  - If the issued level becomes masked before acknowledge, `irq_out` drops to 0 and `pending` is kept.
- **Return guard:** `irq_out` is forced to 0 for the cycle after any `done` bit is sampled, and for the following cycle. This lets the PC restore from its backup before a new request arrives.
- **`cur_level`:** combinational priority encode of `running`: 3 over 2 over 1, else 0.
- **`svc_cnt`:** +1 per acknowledge detected. If two levels are acknowledged in the same cycle, it adds +2. It saturates at 2^CNT_W−1.
- **`err_done`:** set when `done[i] & ~running[i]`; cleared only by reset.

## Timing
- Raw high first sampled at edge 0:
  - `pending` is high after edge `SYNC_STAGES`;
  - `irq_out` is high after edge `SYNC_STAGES+1` if eligible.
  - With defaults, that is 3 edges from raw input to request.
- `irq_out` holds until the edge after the acknowledge is detected, then goes 0. The PC's `running` is sampled registered through `running_d`, so the block tolerates the PC setting `running` mid-cycle.
- `done` pulse at edge d: `irq_out` is 0 after edges d+1 and d+2. It can re-issue after edge d+3.
- Reset mid-service: all outputs return to 0 at the reset edge. `running` and `done` are ignored while `clr_n`=0.

## Structure
- Package `irq_pkg`:
  - `NUM_LVL`=3;
  - level constants `LVL_USER`=0, `LVL1`..`LVL3`;
  - vector addresses `VEC1`=32'h38, `VEC2`=32'h70, `VEC3`=32'hA8, shared with the PC.
- Sub-module `irq_sync_edge`: parameterised synchroniser plus edge detector, one instance per level, exposing `sync` and `rise`.
- Top level contains the pending latches, priority/issue logic, return guard, counter and error flags.

## Test plan
- Reset, then pulse `irq_raw`=3'b001 for 1 cycle → `pending`=001 after 2 edges, `irq_out`=001 after 3 edges. Set `running`=001 → `irq_out`=000 next edge, `pending`=000, `svc_cnt`=1, `cur_level`=1.
- While level 1 runs, pulse level 3 → `irq_out`=100. Acknowledge → `cur_level`=3. Pulse level 2 → `irq_out` stays 000 until `running[2]` clears.
- Raise levels 1 and 2 together with no acknowledge → `irq_out`=010 only. Acknowledge → `irq_out`=001 issued once `running`=010 clears.
- Assert `done`=001 with `running`=001, then drop `running` → `irq_out` stays 0 for 2 cycles even with level 2 pending, then `irq_out`=010.
- Two level-1 edges with no acknowledge → `lost`=1, `pending`=001, `svc_cnt` unchanged. `done`=010 with `running`=000 → `err_done`=1, held until `clr_n`=0.
- `irq_mask`=001 with level 1 pending → `irq_out`=000. Unmask → `irq_out`=001 next edge. Apply `clr_n`=0 mid-request → all outputs 0 at that edge.

Source files
------------

// File: rtl/irq_ctrl_pkg.sv
// Shared interrupt-level definitions: level encoding, vector addresses, priority helpers.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package irq_pkg;

    localparam int NUM_LVL = 3;

    typedef enum logic [1:0] {
        LVL_USER = 2'd0,
        LVL1     = 2'd1,
        LVL2     = 2'd2,
        LVL3     = 2'd3
    } lvl_e;

    // Entry points shared with the PC; the PC jumps here when it takes a level.
    localparam logic [31:0] VEC1 = 32'h38;
    localparam logic [31:0] VEC2 = 32'h70;
    localparam logic [31:0] VEC3 = 32'hA8;

    // One-hot of the highest set bit; zero when nothing is requested.
    function automatic logic [NUM_LVL-1:0] top_onehot(input logic [NUM_LVL-1:0] req);
        logic [NUM_LVL-1:0] oh;
        oh = '0;
        for (int i = 0; i < NUM_LVL; i++) begin
            if (req[i]) begin
                oh    = '0;
                oh[i] = 1'b1;
            end
        end
        return oh;
    endfunction

    // Highest running level wins: 3 over 2 over 1, else user code.
    function automatic lvl_e highest_lvl(input logic [NUM_LVL-1:0] run);
        if (run[2])      return LVL3;
        else if (run[1]) return LVL2;
        else if (run[0]) return LVL1;
        else             return LVL_USER;
    endfunction

    // Number of levels acknowledged in one cycle (0..3).
    function automatic logic [1:0] popcnt3(input logic [NUM_LVL-1:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
    endfunction

endpackage

// File: rtl/irq_ctrl_if.sv
// Bundle between the interrupt controller and its PC/decoder neighbours.
// Latency: n/a (wires only). Backpressure: none; requests are held until acknowledged.
// Ports: slave = controller side (raw/mask/running/done in, request/status out); master = driver side.
interface irq_ctrl_if #(
    parameter int CNT_W = 8
);
    import irq_pkg::*;

    logic [NUM_LVL-1:0] irq_raw;
    logic [NUM_LVL-1:0] irq_mask;
    logic [NUM_LVL-1:0] running;
    logic [NUM_LVL-1:0] done;
    logic [NUM_LVL-1:0] irq_out;
    logic [NUM_LVL-1:0] pending;
    logic [1:0]         cur_level;
    logic [CNT_W-1:0]   svc_cnt;
    logic               lost;
    logic               err_done;

    modport slave (
        input  irq_raw, irq_mask, running, done,
        output irq_out, pending, cur_level, svc_cnt, lost, err_done
    );

    modport master (
        output irq_raw, irq_mask, running, done,
        input  irq_out, pending, cur_level, svc_cnt, lost, err_done
    );

endinterface

// File: rtl/irq_ctrl_sync_edge.sv
// Synchronises one asynchronous interrupt line and flags its rising edge.
// Latency: o_sync follows i_raw after STAGES edges; o_rise is high for one cycle while o_sync is new.
// Backpressure: none. Ports: i_clk, i_clr_n (sync, active-low), i_raw in; o_sync, o_rise out.
module irq_sync_edge #(
    parameter int STAGES = 2   // at least 2 for metastability settling
) (
    input  logic i_clk,
    input  logic i_clr_n,
    input  logic i_raw,
    output logic o_sync,
    output logic o_rise
);

    logic [STAGES-1:0] r_sync;
    logic              r_sync_d;

    always_ff @(posedge i_clk) begin
        if (!i_clr_n) begin
            r_sync   <= '0;
            r_sync_d <= 1'b0;
        end else begin
            r_sync   <= {r_sync[STAGES-2:0], i_raw};
            r_sync_d <= r_sync[STAGES-1];
        end
    end

    assign o_sync = r_sync[STAGES-1];
    // Edge registers clear on reset, so a line already high at release yields one edge.
    assign o_rise = r_sync[STAGES-1] & ~r_sync_d;

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: latches source edges as pending and issues one request at a time to the PC.
// Latency: raw edge -> pending after SYNC_STAGES edges, -> irq_out one edge later.
// Backpressure: a request is held on irq_out until the PC acknowledges by raising running.
// Ports: clk, clr_n (sync, active-low); bus (slave) carries raw/mask/running/done and all outputs.
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       clr_n,
    irq_ctrl_if.slave  bus
);

    logic [NUM_LVL-1:0] w_sync;
    logic [NUM_LVL-1:0] w_rise;
    logic [NUM_LVL-1:0] w_run;
    logic [NUM_LVL-1:0] w_ack;
    logic [NUM_LVL-1:0] w_pend_set;
    logic [NUM_LVL-1:0] w_pend_nxt;
    logic [NUM_LVL-1:0] w_elig;
    lvl_e               w_cur_level;
    logic [CNT_W:0]     w_nack_ext;
    logic [CNT_W:0]     w_cnt_sum;

    logic [NUM_LVL-1:0] r_pending;
    logic [NUM_LVL-1:0] r_irq_out;
    logic [NUM_LVL-1:0] r_running_d;
    logic [1:0]         r_guard;
    logic [CNT_W-1:0]   r_svc_cnt;
    logic               r_lost;
    logic               r_err_done;

    genvar g;
    for (g = 0; g < NUM_LVL; g++) begin : g_lvl
        irq_sync_edge #(
            .STAGES (SYNC_STAGES)
        ) u_sync_edge (
            .i_clk   (clk),
            .i_clr_n (clr_n),
            .i_raw   (bus.irq_raw[g]),
            .o_sync  (w_sync[g]),
            .o_rise  (w_rise[g])
        );
    end

    // The PC's running bits mean nothing while we are held in reset.
    assign w_run       = clr_n ? bus.running : '0;
    assign w_cur_level = highest_lvl(w_run);

    // Acknowledge is the rising edge of running against last cycle's sample.
    assign w_ack      = w_run & ~r_running_d;
    assign w_pend_set = w_rise & w_sync;
    // A new edge wins over a same-cycle acknowledge so that request is not dropped.
    assign w_pend_nxt = (r_pending & ~w_ack) | w_pend_set;

    always_comb begin
        w_elig = '0;
        for (int i = 0; i < NUM_LVL; i++) begin
            w_elig[i] = r_pending[i] & ~bus.irq_mask[i] & ~w_run[i]
                      & ((i + 1) > int'(w_cur_level));
        end
    end

    assign w_nack_ext = {{(CNT_W-1){1'b0}}, popcnt3(w_ack)};
    assign w_cnt_sum  = {1'b0, r_svc_cnt} + w_nack_ext;

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            r_pending   <= '0;
            r_irq_out   <= '0;
            r_running_d <= '0;
            r_guard     <= '0;
            r_svc_cnt   <= '0;
            r_lost      <= 1'b0;
            r_err_done  <= 1'b0;
        end else begin
            r_running_d <= w_run;
            r_pending   <= w_pend_nxt;
            // Two quiet cycles after a return give the PC time to restore its context.
            r_irq_out   <= (|r_guard) ? '0 : top_onehot(w_elig);
            r_guard     <= {r_guard[0], |bus.done};
            if (w_cnt_sum[CNT_W]) begin
                r_svc_cnt <= '1;
            end else begin
                r_svc_cnt <= w_cnt_sum[CNT_W-1:0];
            end
            if (|(w_pend_set & r_pending & ~w_ack)) begin
                r_lost <= 1'b1;
            end
            if (|(bus.done & ~w_run)) begin
                r_err_done <= 1'b1;
            end
        end
    end

    assign bus.irq_out   = r_irq_out;
    assign bus.pending   = r_pending;
    assign bus.cur_level = w_cur_level;
    assign bus.svc_cnt   = r_svc_cnt;
    assign bus.lost      = r_lost;
    assign bus.err_done  = r_err_done;

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: level table, directed multi-cycle sequences, random vs. model.
// Latency: n/a. Backpressure: n/a.
module tb_irq_ctrl;

    localparam int SYNC = 2;
    localparam int CW   = 8;
    localparam int MAXC = 255;

    logic clk = 1'b0;
    logic clr_n;
    always #5 clk = ~clk;

    irq_ctrl_if #(.CNT_W(CW)) bus ();

    irq_ctrl #(
        .SYNC_STAGES (SYNC),
        .CNT_W       (CW)
    ) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    // ---------------- reference model ----------------
    // Pipeline of raw samples per level; index 0 is the most recent edge's sample.
    logic       m_hist [3][SYNC+1];
    logic [2:0] m_pend, m_prev_run, m_out;
    int         m_cnt, m_quiet;
    logic       m_lost, m_err;

    function automatic int top_run(input logic [2:0] run);
        for (int lv = 3; lv >= 1; lv--) if (run[lv-1]) return lv;
        return 0;
    endfunction

    task automatic model_step();
        int   cur, best, nack;
        logic rise, ack;
        if (!clr_n) begin
            for (int l = 0; l < 3; l++)
                for (int k = 0; k <= SYNC; k++) m_hist[l][k] = 1'b0;
            m_pend = '0; m_prev_run = '0; m_out = '0;
            m_cnt = 0; m_quiet = 0; m_lost = 1'b0; m_err = 1'b0;
        end else begin
            cur  = top_run(bus.running);
            best = 0;
            for (int lv = 1; lv <= 3; lv++)
                if (m_pend[lv-1] && !bus.irq_mask[lv-1] && lv > cur && !bus.running[lv-1]) best = lv;
            m_out = (m_quiet > 0 || best == 0) ? 3'b000 : 3'(1 << (best - 1));
            nack = 0;
            for (int l = 0; l < 3; l++) begin
                rise = m_hist[l][SYNC-1] && !m_hist[l][SYNC];
                ack  = bus.running[l] && !m_prev_run[l];
                if (ack) nack++;
                if (rise && m_pend[l] && !ack) m_lost = 1'b1;
                if (rise) m_pend[l] = 1'b1;
                else if (ack) m_pend[l] = 1'b0;
                if (bus.done[l] && !bus.running[l]) m_err = 1'b1;
                for (int k = SYNC; k > 0; k--) m_hist[l][k] = m_hist[l][k-1];
                m_hist[l][0] = bus.irq_raw[l];
            end
            m_prev_run = bus.running;
            m_cnt = (m_cnt + nack > MAXC) ? MAXC : m_cnt + nack;
            if (|bus.done) m_quiet = 2;
            else if (m_quiet > 0) m_quiet--;
        end
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            model_step();
            #1;
        end
    endtask

    task automatic do_reset();
        clr_n = 1'b0;
        bus.irq_raw = '0; bus.irq_mask = '0; bus.running = '0; bus.done = '0;
        step(2);
        clr_n = 1'b1;
    endtask

    task automatic chk_out(input string name, input int e_out, input int e_pend);
        chk({name, "_irq_out"}, int'(bus.irq_out), e_out);
        chk({name, "_pending"}, int'(bus.pending), e_pend);
    endtask

    typedef struct {
        logic       clr_n;
        logic [2:0] running;
        int         exp_lvl;
    } lvl_vec_t;

    lvl_vec_t tbl [10];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        clr_n = 1'b0;
        bus.irq_raw = '0; bus.irq_mask = '0; bus.running = '0; bus.done = '0;

        tbl[0] = '{1'b1, 3'b000, 0}; tbl[1] = '{1'b1, 3'b001, 1};
        tbl[2] = '{1'b1, 3'b010, 2}; tbl[3] = '{1'b1, 3'b011, 2};
        tbl[4] = '{1'b1, 3'b100, 3}; tbl[5] = '{1'b1, 3'b101, 3};
        tbl[6] = '{1'b1, 3'b110, 3}; tbl[7] = '{1'b1, 3'b111, 3};
        tbl[8] = '{1'b0, 3'b111, 0}; tbl[9] = '{1'b0, 3'b010, 0};

        // Reset state
        do_reset();
        chk_out("rst", 0, 0);
        chk("rst_svc_cnt", int'(bus.svc_cnt), 0);
        chk("rst_lost", int'(bus.lost), 0);
        chk("rst_err_done", int'(bus.err_done), 0);
        chk("rst_cur_level", int'(bus.cur_level), 0);

        // cur_level priority table
        for (int i = 0; i < 10; i++) begin
            clr_n = tbl[i].clr_n;
            bus.running = tbl[i].running;
            #2;
            chk($sformatf("tbl%0d_cur_level", i), int'(bus.cur_level), tbl[i].exp_lvl);
            step();
        end

        // Single level-1 pulse: pending after 2 edges, request after 3, then acknowledge
        do_reset();
        bus.irq_raw = 3'b001; step();
        bus.irq_raw = 3'b000; step();
        chk_out("l1_e1", 0, 0);
        step();
        chk_out("l1_e2", 0, 'b001);
        step();
        chk_out("l1_e3", 'b001, 'b001);
        bus.running = 3'b001; step();
        chk_out("l1_ack", 0, 0);
        chk("l1_ack_svc_cnt", int'(bus.svc_cnt), 1);
        chk("l1_ack_cur_level", int'(bus.cur_level), 1);

        // Level 3 preempts running level 1; level 2 waits until level 3 returns
        bus.irq_raw = 3'b100; step();
        bus.irq_raw = 3'b000; step(3);
        chk_out("l3_issue", 'b100, 'b100);
        bus.running = 3'b101; step();
        chk_out("l3_ack", 0, 0);
        chk("l3_ack_cur_level", int'(bus.cur_level), 3);
        chk("l3_ack_svc_cnt", int'(bus.svc_cnt), 2);
        bus.irq_raw = 3'b010; step();
        bus.irq_raw = 3'b000; step(3);
        chk_out("l2_blocked", 0, 'b010);
        bus.running = 3'b001; step();
        chk_out("l2_after_l3", 'b010, 'b010);

        // Levels 1 and 2 together: only 2 issued, 1 follows once 2 stops running
        do_reset();
        bus.irq_raw = 3'b011; step();
        bus.irq_raw = 3'b000; step(3);
        chk_out("dual_issue", 'b010, 'b011);
        bus.running = 3'b010; step();
        chk_out("dual_ack", 0, 'b001);
        chk("dual_ack_svc_cnt", int'(bus.svc_cnt), 1);
        step();
        chk_out("dual_hold", 0, 'b001);
        bus.running = 3'b000; step();
        chk_out("dual_l1", 'b001, 'b001);

        // Return guard: two quiet cycles after done even with a pending request
        do_reset();
        bus.irq_raw = 3'b100; step();
        bus.irq_raw = 3'b000; step(3);
        chk_out("grd_l3", 'b100, 'b100);
        bus.running = 3'b100; step();
        bus.irq_raw = 3'b010; step();
        bus.irq_raw = 3'b000; step(3);
        chk_out("grd_l2_wait", 0, 'b010);
        bus.done = 3'b100; step();
        bus.done = 3'b000; bus.running = 3'b000;
        chk_out("grd_d0", 0, 'b010);
        step();
        chk_out("grd_d1", 0, 'b010);
        step();
        chk_out("grd_d2", 0, 'b010);
        step();
        chk_out("grd_d3", 'b010, 'b010);
        chk("grd_err_done", int'(bus.err_done), 0);

        // Merged edge sets lost; done without running sets err_done until reset
        do_reset();
        bus.irq_raw = 3'b001; step();
        bus.irq_raw = 3'b000; step();
        bus.irq_raw = 3'b001; step();
        bus.irq_raw = 3'b000; step(3);
        chk("lost_set", int'(bus.lost), 1);
        chk_out("lost", 'b001, 'b001);
        chk("lost_svc_cnt", int'(bus.svc_cnt), 0);
        bus.done = 3'b010; step();
        bus.done = 3'b000;
        chk("err_set", int'(bus.err_done), 1);
        step(3);
        chk("err_sticky", int'(bus.err_done), 1);
        do_reset();
        chk("err_cleared", int'(bus.err_done), 0);
        chk("lost_cleared", int'(bus.lost), 0);

        // Masking holds the request back; reset mid-request clears everything
        do_reset();
        bus.irq_mask = 3'b001;
        bus.irq_raw = 3'b001; step();
        bus.irq_raw = 3'b000; step(3);
        chk_out("mask_hold", 0, 'b001);
        bus.irq_mask = 3'b000; step();
        chk_out("unmask", 'b001, 'b001);
        clr_n = 1'b0; bus.running = 3'b001; bus.done = 3'b001; step();
        chk_out("midrst", 0, 0);
        chk("midrst_svc_cnt", int'(bus.svc_cnt), 0);
        chk("midrst_err_done", int'(bus.err_done), 0);
        chk("midrst_cur_level", int'(bus.cur_level), 0);
        clr_n = 1'b1; bus.running = '0; bus.done = '0;

        // Counter: double acknowledge adds 2, saturates at the top
        do_reset();
        bus.running = 3'b011; step();
        chk("cnt_dbl", int'(bus.svc_cnt), 2);
        bus.running = 3'b000; step();
        for (int k = 0; k < 126; k++) begin
            bus.running = 3'b011; step();
            bus.running = 3'b000; step();
        end
        chk("cnt_254", int'(bus.svc_cnt), 254);
        bus.running = 3'b011; step();
        chk("cnt_sat", int'(bus.svc_cnt), MAXC);
        bus.running = 3'b000; step();
        bus.running = 3'b011; step();
        chk("cnt_sat_hold", int'(bus.svc_cnt), MAXC);

        // Random stimulus against the model
        do_reset();
        for (int c = 0; c < 2500; c++) begin
            chk("rnd_irq_out", int'(bus.irq_out), int'(m_out));
            chk("rnd_pending", int'(bus.pending), int'(m_pend));
            chk("rnd_svc_cnt", int'(bus.svc_cnt), m_cnt);
            chk("rnd_lost", int'(bus.lost), int'(m_lost));
            chk("rnd_err_done", int'(bus.err_done), int'(m_err));
            chk("rnd_cur_level", int'(bus.cur_level), clr_n ? top_run(bus.running) : 0);
            clr_n = ($urandom_range(0, 199) != 0);
            for (int b = 0; b < 3; b++) begin
                if ($urandom_range(0, 5) == 0)  bus.irq_raw[b]  = ~bus.irq_raw[b];
                if ($urandom_range(0, 39) == 0) bus.irq_mask[b] = ~bus.irq_mask[b];
                if ($urandom_range(0, 7) == 0)  bus.running[b]  = ~bus.running[b];
                bus.done[b] = ($urandom_range(0, 19) == 0);
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
